// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Registered instruction address with async reset, level load
//               and modulo-2^ADDR_W sequential advance by INC_STEP.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0,
  parameter int                INC_STEP = 1
) (
  input  logic              clk,
  input  logic              Pc_Rst,
  input  logic              Pc_Ld,
  input  logic [ADDR_W-1:0] Pc_addr_in,
  output logic [ADDR_W-1:0] inst_addr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INC_STEP);

  logic [ADDR_W-1:0] pc_reg;

  // Load wins over advance; the sum truncates naturally so the PC wraps.
  always_ff @(posedge clk or negedge Pc_Rst) begin
    if (!Pc_Rst) begin
      pc_reg <= RST_ADDR;
    end else if (Pc_Ld) begin
      pc_reg <= Pc_addr_in;
    end else begin
      pc_reg <= pc_reg + STEP;
    end
  end

  assign inst_addr = pc_reg;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Scoreboard bench for program_counter (default and 8-bit build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        ld;
  logic [15:0] addr;
  logic [15:0] pc;

  logic        rst8_n;
  logic        ld8;
  logic [7:0]  addr8;
  logic [7:0]  pc8;

  int          tests;
  int          fails;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  logic [15:0] model;
  logic [7:0]  model8;

  program_counter dut (
    .clk        (clk),
    .Pc_Rst     (rst_n),
    .Pc_Ld      (ld),
    .Pc_addr_in (addr),
    .inst_addr  (pc)
  );

  program_counter #(
    .ADDR_W   (8),
    .RST_ADDR (8'h10),
    .INC_STEP (2)
  ) dut8 (
    .clk        (clk),
    .Pc_Rst     (rst8_n),
    .Pc_Ld      (ld8),
    .Pc_addr_in (addr8),
    .inst_addr  (pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-state for the 16-bit, step-1 build.
  function automatic logic [15:0] next_pc(input logic l, input logic [15:0] a,
                                          input logic [15:0] cur);
    return l ? a : cur + 16'd1;
  endfunction

  task automatic test_reset();
    exp_q.push_back(16'h0000);
    #1;
    exp_v = exp_q.pop_front();
    tests++;
    if (pc !== exp_v) begin
      fails++;
      $display("FAIL reset_t0 got=%h exp=%h", pc, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'h0000);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL reset_edge%0d got=%h exp=%h", i, pc, exp_v);
      end
      exp_q.push_back(16'h0000);
      @(negedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL reset_between%0d got=%h exp=%h", i, pc, exp_v);
      end
    end
    model = 16'h0000;
  endtask

  task automatic test_increment();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      model = next_pc(ld, addr, model);
      exp_q.push_back(model);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL increment%0d got=%h exp=%h", i, pc, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    ld   = 1'b1;
    addr = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) ld = 1'b0;
      model = next_pc(ld, addr, model);
      exp_q.push_back(model);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL load%0d got=%h exp=%h", i, pc, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    // At a negedge with pc == 0F11; assert reset with a pending load.
    ld    = 1'b1;
    addr  = 16'h5555;
    rst_n = 1'b0;
    model = 16'h0000;
    exp_q.push_back(model);
    #1;
    exp_v = exp_q.pop_front();
    tests++;
    if (pc !== exp_v) begin
      fails++;
      $display("FAIL async_assert got=%h exp=%h", pc, exp_v);
    end
    exp_q.push_back(model);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    tests++;
    if (pc !== exp_v) begin
      fails++;
      $display("FAIL async_hold got=%h exp=%h", pc, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ld    = 1'b0;
    model = next_pc(ld, addr, model);
    exp_q.push_back(model);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    tests++;
    if (pc !== exp_v) begin
      fails++;
      $display("FAIL async_release_inc got=%h exp=%h", pc, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    ld    = 1'b1;
    addr  = 16'h1234;
    model = next_pc(ld, addr, 16'h0000);
    exp_q.push_back(model);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    tests++;
    if (pc !== exp_v) begin
      fails++;
      $display("FAIL async_release_ld got=%h exp=%h", pc, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    ld   = 1'b1;
    addr = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ld = 1'b0;
      model = next_pc(ld, addr, model);
      exp_q.push_back(model);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL wrap%0d got=%h exp=%h", i, pc, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    // Target changes every edge; a glitch just after each edge must not leak.
    logic [15:0] targets [4] = '{16'hA000, 16'h0001, 16'h7FFE, 16'hBEEF};
    ld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr  = targets[i];
      model = next_pc(ld, addr, model);
      exp_q.push_back(model);
      exp_q.push_back(model);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL b2b_load%0d got=%h exp=%h", i, pc, exp_v);
      end
      addr = ~targets[i];
      #1;
      exp_v = exp_q.pop_front();
      tests++;
      if (pc !== exp_v) begin
        fails++;
        $display("FAIL b2b_midglitch%0d got=%h exp=%h", i, pc, exp_v);
      end
      @(negedge clk);
    end
    ld = 1'b0;
  endtask

  task automatic test_params();
    logic [7:0] seq_ld [4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] seq_addr [4] = '{8'h00, 8'h00, 8'hFF, 8'h00};
    model8 = 8'h10;
    exp_q.push_back({8'h00, model8});
    #1;
    exp_v = exp_q.pop_front();
    tests++;
    if ({8'h00, pc8} !== exp_v) begin
      fails++;
      $display("FAIL param_reset got=%h exp=%h", pc8, exp_v[7:0]);
    end
    @(negedge clk);
    rst8_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld8    = seq_ld[i][0];
      addr8  = seq_addr[i];
      model8 = ld8 ? addr8 : model8 + 8'd2;
      exp_q.push_back({8'h00, model8});
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      tests++;
      if ({8'h00, pc8} !== exp_v) begin
        fails++;
        $display("FAIL param_step%0d got=%h exp=%h", i, pc8, exp_v[7:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    ld     = 1'b0;
    addr   = 16'h0F0F;
    rst8_n = 1'b0;
    ld8    = 1'b0;
    addr8  = 8'h00;
    model  = 16'h0000;
    model8 = 8'h10;

    test_reset();
    test_increment();
    test_load();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    test_params();

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
